// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and defaults for the instruction fetch queue
package fetch_queue_pkg;

    localparam int FQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side enqueue and decode-side dequeue bundle
import fetch_queue_pkg::*;

interface fetch_queue_if #(
    parameter int DEPTH = FQ_DEPTH_DEFAULT
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]    imem_addr_F;
    logic [31:0]    imem_data_F;
    logic           enq_valid_F;
    logic           enq_ready_F;
    logic           flush_F;
    logic [31:0]    instr_D;
    logic [63:0]    pc_D;
    logic           valid_D;
    logic           ready_D;
    logic [PTR_W:0] count_Q;

    modport master (
        output imem_addr_F, imem_data_F, enq_valid_F, flush_F, ready_D,
        input  enq_ready_F, instr_D, pc_D, valid_D, count_Q
    );

    modport slave (
        input  imem_addr_F, imem_data_F, enq_valid_F, flush_F, ready_D,
        output enq_ready_F, instr_D, pc_D, valid_D, count_Q
    );

endinterface

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - unreset entry array, one sync write port and one async read port
import fetch_queue_pkg::*;

module fq_storage #(
    parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fq_entry_t                rdata
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order prefetch buffer between fetch and decode with flush
import fetch_queue_pkg::*;

module fetch_queue #(
    parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             enq;
    logic             deq;
    fq_entry_t        wr_entry;
    fq_entry_t        head;

    // Ready/valid come only from the registered count, so a full queue
    // refuses fetch even when decode drains the head in the same cycle.
    assign fq.enq_ready_F = (count != FULL_COUNT);
    assign fq.valid_D     = (count != '0);
    assign fq.count_Q     = count;

    assign enq = fq.enq_valid_F && fq.enq_ready_F && !reset && !fq.flush_F;
    assign deq = fq.valid_D && fq.ready_D && !reset && !fq.flush_F;

    assign wr_entry.pc    = fq.imem_addr_F;
    assign wr_entry.instr = fq.imem_data_F;

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign fq.instr_D = fq.valid_D ? head.instr : '0;
    assign fq.pc_D    = fq.valid_D ? head.pc    : '0;

    always_ff @(posedge clk) begin
        if (reset || fq.flush_F) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized checks of fetch_queue against a queue model
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH)) fq_if ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_pc[$];
    logic [31:0] m_instr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [63:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl, input logic rs);
        fq_if.enq_valid_F = ev;
        fq_if.imem_addr_F = pc;
        fq_if.imem_data_F = ins;
        fq_if.ready_D     = rdy;
        fq_if.flush_F     = fl;
        reset             = rs;
    endtask

    task automatic check_model();
        int n;
        n = m_pc.size();
        check("count_Q", 64'(fq_if.count_Q), 64'(n));
        check("valid_D", 64'(fq_if.valid_D), 64'(n != 0));
        check("enq_ready_F", 64'(fq_if.enq_ready_F), 64'(n != DEPTH));
        check("pc_D", fq_if.pc_D, (n != 0) ? m_pc[0] : 64'h0);
        check("instr_D", 64'(fq_if.instr_D), (n != 0) ? 64'(m_instr[0]) : 64'h0);
    endtask

    // Inputs are already driven; the model applies queue rules at the edge
    // and outputs are compared half a cycle later.
    task automatic step();
        int  n;
        bit  do_deq;
        bit  do_enq;
        @(posedge clk);
        n = m_pc.size();
        if (reset || fq_if.flush_F) begin
            m_pc.delete();
            m_instr.delete();
        end else begin
            do_deq = (n != 0) && fq_if.ready_D;
            do_enq = fq_if.enq_valid_F && (n < DEPTH);
            if (do_deq) begin
                void'(m_pc.pop_front());
                void'(m_instr.pop_front());
            end
            if (do_enq) begin
                m_pc.push_back(fq_if.imem_addr_F);
                m_instr.push_back(fq_if.imem_data_F);
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic drain();
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= DEPTH; i++) step();
    endtask

    initial begin
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", 64'(fq_if.valid_D), 64'h0);
            check("idle_ready", 64'(fq_if.enq_ready_F), 64'h1);
            check("idle_pc", fq_if.pc_D, 64'h0);
        end

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i), 32'h8B020020 + 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        check("fill_count", 64'(fq_if.count_Q), 64'd4);
        check("fill_ready", 64'(fq_if.enq_ready_F), 64'd0);
        drive(1'b1, 64'h10, 32'h8B020024, 1'b0, 1'b0, 1'b0);
        step();
        check("fill_head_pc", fq_if.pc_D, 64'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            check("drain_pc", fq_if.pc_D, 64'(4 * i));
            check("drain_instr", 64'(fq_if.instr_D), 64'(32'h8B020020 + 32'(i)));
            step();
        end

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h100 + 64'(4 * i), 32'hA000 + 32'(i), 1'b1, 1'b0, 1'b0);
            step();
            check("stream_count", 64'(fq_if.count_Q), 64'd1);
            check("stream_pc", fq_if.pc_D, 64'h100 + 64'(4 * i));
        end
        drain();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h300 + 64'(4 * i), 32'hB000 + 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h310, 32'hB004, 1'b1, 1'b0, 1'b0);
        step();
        check("full_deq_count", 64'(fq_if.count_Q), 64'd3);
        step();
        check("after_full_count", 64'(fq_if.count_Q), 64'd3);
        drain();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h20 + 64'(4 * i), 32'hC000 + 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h40, 32'hC010, 1'b1, 1'b1, 1'b0);
        step();
        check("flush_count", 64'(fq_if.count_Q), 64'd0);
        check("flush_valid", 64'(fq_if.valid_D), 64'd0);
        drive(1'b1, 64'h200, 32'hD000, 1'b0, 1'b0, 1'b0);
        step();
        check("post_flush_pc", fq_if.pc_D, 64'h200);
        drain();

        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h500 + 64'(4 * i), 32'hE000 + 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h600, 32'hE100, 1'b0, 1'b1, 1'b1);
        step();
        check("reset_count", 64'(fq_if.count_Q), 64'd0);
        check("reset_valid", 64'(fq_if.valid_D), 64'd0);
        drive(1'b1, 64'h700, 32'hE200, 1'b0, 1'b0, 1'b0);
        step();
        check("post_reset_pc", fq_if.pc_D, 64'h700);
        drain();

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, $urandom(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer sitting directly downstream of the fetch stage.
- Captures {PC, instruction} pairs from fetch/imem, one per cycle, and presents them in order to decode through a valid/ready handshake.
- Back-pressures fetch (hold PC) when full.
- Discards all buffered entries on a taken branch (flush).

Parameters:
- DEPTH, 4, number of entries; power of 2, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_addr_F  input  64  PC of the instruction being fetched
- imem_data_F  input  32  instruction word read at imem_addr_F
- enq_valid_F  input  1  fetch offers an entry this cycle
- enq_ready_F  output  1  queue accepts an entry; fetch holds PC when low
- flush_F  input  1  taken branch (PCSrc); discard all entries
- instr_D  output  32  head instruction
- pc_D  output  64  head PC
- valid_D  output  1  head entry valid
- ready_D  input  1  decode consumes head this cycle
- count_Q  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (sync, at posedge with reset=1):
  - wr_ptr, rd_ptr and count go to 0.
  - valid_D=0, enq_ready_F=1, count_Q=0.
  - Storage contents are don't-care.
- Reset asserted mid-operation: same as above; all entries lost; no enqueue or dequeue takes effect that cycle.
- Handshakes:
  - Enqueue occurs when enq_valid_F && enq_ready_F. Entry {imem_addr_F, imem_data_F} is written at wr_ptr; wr_ptr increments.
  - Dequeue occurs when valid_D && ready_D; rd_ptr increments.
- Outputs derived from count:
  - enq_ready_F = (count != DEPTH), combinational from registered count only.
  - valid_D = (count != 0).
- Show-ahead: instr_D/pc_D reflect storage[rd_ptr] combinationally; both are forced to 0 when valid_D=0.
- Latency: an entry enqueued at edge N is visible on valid_D after edge N; there is no same-cycle bypass when empty.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Full: enq_ready_F=0 even if decode dequeues the same cycle; no enqueue-through-full.
- Empty: a dequeue is impossible (valid_D=0); ready_D is ignored.
- Pointer wrap-around: pointers are PTR_W bits and wrap naturally from DEPTH-1 to 0; count distinguishes full from empty.
- Flush (flush_F=1 at edge):
  - Pointers and count go to 0.
  - Flush has priority over any enqueue or dequeue in the same cycle; the offered entry is dropped even if enq_ready_F was 1.
  - Next cycle: valid_D=0, enq_ready_F=1.
- reset has priority over flush_F.
- count_Q is registered; it updates as count + enq - deq, with enq and deq evaluated after flush/reset masking.

Decomposition:
- Package fetch_queue_pkg:
  - typedef fq_entry_t as a packed struct {logic [63:0] pc; logic [31:0] instr}.
  - localparam FQ_DEPTH_DEFAULT = 4.
- Sub-module fq_storage: register array of DEPTH fq_entry_t.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset on the array.
- Pointer, count, flush and handshake control live in fetch_queue.

Test Plan:
- Reset then idle → valid_D=0, enq_ready_F=1, count_Q=0, instr_D=0, pc_D=0 for 3 cycles.
- Fill with ready_D=0: enqueue PC 0x0/0x4/0x8/0xC with instr 0x8B020020+i → after 4th edge count_Q=4, enq_ready_F=0. A 5th offer (PC 0x10) is ignored; then dequeue returns PC 0x0,0x4,0x8,0xC in order with the matching instructions.
- Streaming: enq_valid_F=1 and ready_D=1 for 10 cycles, PC stepping by 4 from 0x100 → count_Q holds at 1 after the first edge; pc_D sequence is 0x100,0x104,… with no gaps; pointers wrap past DEPTH.
- Full plus simultaneous dequeue: count=4, ready_D=1, enq_valid_F=1 → enqueue refused (enq_ready_F=0), count_Q=3 next cycle; following cycle enqueue accepted.
- Flush with 3 entries, plus a concurrent enqueue of PC 0x40 and dequeue → next cycle count_Q=0, valid_D=0. Then enqueue PC 0x200 → pc_D=0x200 one cycle later.
- Reset asserted together with flush_F and enq_valid_F, with 2 entries held → count_Q=0 and valid_D=0 next cycle, no entry retained; normal enqueue works the cycle after reset deasserts.
